// File: rtl/md_wb_pkg.sv
// Shared cell-code constants, writeback classes and half-shell classification
// for the MD cell node writeback path.
package md_wb_pkg;
  localparam int CELL_W = 3;

  localparam logic [CELL_W-1:0] CELL_1 = 3'd1;
  localparam logic [CELL_W-1:0] CELL_2 = 3'd2;
  localparam logic [CELL_W-1:0] CELL_3 = 3'd3;

  typedef struct packed {
    logic [CELL_W-1:0] z;
    logic [CELL_W-1:0] y;
    logic [CELL_W-1:0] x;
  } cell_t;

  localparam cell_t HOME_TRIPLE = '{z: CELL_2, y: CELL_2, x: CELL_2};

  typedef enum logic [1:0] {WB_LOCAL, WB_REMOTE, WB_ILLEGAL} wb_class_t;

  function automatic logic in_shell_range(input logic [CELL_W-1:0] c);
    return (c >= CELL_1) && (c <= CELL_3);
  endfunction

  // The 13 neighbours whose (dz,dy,dx) offset is lexicographically positive.
  function automatic logic is_half_shell(input logic [CELL_W-1:0] z,
                                         input logic [CELL_W-1:0] y,
                                         input logic [CELL_W-1:0] x);
    logic hs;
    hs = 1'b0;
    if (z == CELL_2 && y == CELL_2 && x == CELL_3) hs = 1'b1;
    if (z == CELL_2 && y == CELL_3 && in_shell_range(x)) hs = 1'b1;
    if (z == CELL_3 && in_shell_range(y) && in_shell_range(x)) hs = 1'b1;
    return hs;
  endfunction

  function automatic wb_class_t classify(input cell_t c);
    wb_class_t r;
    if (c == HOME_TRIPLE) r = WB_LOCAL;
    else if (is_half_shell(c.z, c.y, c.x)) r = WB_REMOTE;
    else r = WB_ILLEGAL;
    return r;
  endfunction
endpackage

// File: rtl/cell_to_dest_mapper.sv
// Maps a neighbour cell triple (codes 1..3 = offset -1..+1 from home) to the
// destination node id on a periodic NX x NY x NZ grid.
module cell_to_dest_mapper #(
  parameter int CELL_ID_WIDTH = 3,
  parameter int NODE_ID_WIDTH = 6,
  parameter int NUM_CELLS     = 64,
  parameter int HOME_CELL_ID  = 0,
  parameter int HOME_X        = 1,
  parameter int HOME_Y        = 1,
  parameter int HOME_Z        = 1,
  parameter int NX            = 4,
  parameter int NY            = 4,
  parameter int NZ            = 4
) (
  input  logic [CELL_ID_WIDTH-1:0] cell_z,
  input  logic [CELL_ID_WIDTH-1:0] cell_y,
  input  logic [CELL_ID_WIDTH-1:0] cell_x,
  output logic [NODE_ID_WIDTH-1:0] dest_id
);
  function automatic int wrap(input int c, input int n);
    int r;
    if (c < 0) r = c + n;
    else if (c >= n) r = c - n;
    else r = c;
    return r;
  endfunction

  int cx, cy, cz, nid, hops, sum;

  always_comb begin
    cx   = wrap(HOME_X - 1 + int'(cell_x) - 2, NX);
    cy   = wrap(HOME_Y - 1 + int'(cell_y) - 2, NY);
    cz   = wrap(HOME_Z - 1 + int'(cell_z) - 2, NZ);
    nid  = cx + NX * (cy + NY * cz);
    hops = nid - HOME_CELL_ID;
    if (hops < 0) hops = hops + NUM_CELLS;
    // 32-bit sum, folded once, then truncated to the node id width
    sum  = HOME_CELL_ID + hops;
    if (sum >= NUM_CELLS) sum = sum - NUM_CELLS;
    dest_id = NODE_ID_WIDTH'(sum);
  end
endmodule

// File: rtl/wb_dispatch_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer when
// advance is high; the pointer moves past the winner only on a grant.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [PW-1:0]      grant_idx
);
  logic [PW-1:0] pointer;
  logic [PW-1:0] win;
  logic          found;
  int            idx;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(pointer) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    if (advance && found) grant_onehot[win] = 1'b1;
  end

  assign grant_idx = win;

  always_ff @(posedge clk) begin
    if (!rst_n) pointer <= '0;
    else if (advance && found)
      pointer <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  end
endmodule

// File: rtl/wb_dispatch_arbiter.sv
// Classifies force-pipeline writebacks as local / half-shell remote / illegal
// and arbitrates each class independently onto a registered output stage.
module wb_dispatch_arbiter
  import md_wb_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int NUM_CELLS         = 64,
  parameter int DATA_WIDTH        = 32,
  parameter int CELL_ID_WIDTH     = 3,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int WB_WIDTH          = 3*CELL_ID_WIDTH + PARTICLE_ID_WIDTH + 3*DATA_WIDTH,
  parameter int NODE_ID_WIDTH     = 6,
  parameter int PAYLOAD_WIDTH     = 3*DATA_WIDTH + PARTICLE_ID_WIDTH,
  parameter int PACKET_WIDTH      = PAYLOAD_WIDTH + NODE_ID_WIDTH,
  parameter int HOME_CELL_ID      = 0,
  parameter int HOME_X            = 1,
  parameter int HOME_Y            = 1,
  parameter int HOME_Z            = 1,
  parameter int NX                = 4,
  parameter int NY                = 4,
  parameter int NZ                = 4,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          wb_valid,
  input  logic [NUM_REQ*WB_WIDTH-1:0] wb_data,
  output logic [NUM_REQ-1:0]          wb_ready,
  output logic                        pkt_valid,
  output logic [PACKET_WIDTH-1:0]     pkt_data,
  input  logic                        pkt_ready,
  output logic                        local_valid,
  output logic [PAYLOAD_WIDTH-1:0]    local_data,
  input  logic                        local_ready,
  output logic [CNT_WIDTH-1:0]        remote_cnt,
  output logic [CNT_WIDTH-1:0]        local_cnt,
  output logic                        err_illegal_cell
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [NUM_REQ-1:0][WB_WIDTH-1:0]      wb;
  logic [NUM_REQ-1:0][PAYLOAD_WIDTH-1:0] payload;
  logic [NUM_REQ-1:0][NODE_ID_WIDTH-1:0] dest;
  wb_class_t                             cls [NUM_REQ];
  logic [NUM_REQ-1:0] rem_req, loc_req, ill_req, rem_gnt, loc_gnt;
  logic [PW-1:0]      rem_idx, loc_idx;
  logic               pkt_load, local_load;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      assign wb[i]      = wb_data[i*WB_WIDTH +: WB_WIDTH];
      assign payload[i] = wb[i][PAYLOAD_WIDTH-1:0];
      assign cls[i]     = classify(cell_t'(wb[i][WB_WIDTH-1 -: 3*CELL_ID_WIDTH]));
      assign rem_req[i] = wb_valid[i] && (cls[i] == WB_REMOTE);
      assign loc_req[i] = wb_valid[i] && (cls[i] == WB_LOCAL);
      assign ill_req[i] = wb_valid[i] && (cls[i] == WB_ILLEGAL);

      cell_to_dest_mapper #(
        .CELL_ID_WIDTH(CELL_ID_WIDTH), .NODE_ID_WIDTH(NODE_ID_WIDTH),
        .NUM_CELLS(NUM_CELLS), .HOME_CELL_ID(HOME_CELL_ID),
        .HOME_X(HOME_X), .HOME_Y(HOME_Y), .HOME_Z(HOME_Z),
        .NX(NX), .NY(NY), .NZ(NZ)
      ) u_map (
        .cell_z (wb[i][WB_WIDTH-1 -: CELL_ID_WIDTH]),
        .cell_y (wb[i][WB_WIDTH-1-CELL_ID_WIDTH -: CELL_ID_WIDTH]),
        .cell_x (wb[i][PAYLOAD_WIDTH +: CELL_ID_WIDTH]),
        .dest_id(dest[i])
      );
    end
  endgenerate

  assign pkt_load   = !pkt_valid || pkt_ready;
  assign local_load = !local_valid || local_ready;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_remote (
    .clk(clk), .rst_n(rst_n), .req(rem_req), .advance(pkt_load && rst_n),
    .grant_onehot(rem_gnt), .grant_idx(rem_idx)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_local (
    .clk(clk), .rst_n(rst_n), .req(loc_req), .advance(local_load && rst_n),
    .grant_onehot(loc_gnt), .grant_idx(loc_idx)
  );

  // Illegal words are swallowed immediately so they never block a requester.
  assign wb_ready = ill_req | rem_gnt | loc_gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_valid        <= 1'b0;
      pkt_data         <= '0;
      local_valid      <= 1'b0;
      local_data       <= '0;
      remote_cnt       <= '0;
      local_cnt        <= '0;
      err_illegal_cell <= 1'b0;
    end else begin
      if (pkt_load) begin
        pkt_valid <= |rem_gnt;
        if (|rem_gnt) pkt_data <= {dest[rem_idx], payload[rem_idx]};
      end
      if (local_load) begin
        local_valid <= |loc_gnt;
        if (|loc_gnt) local_data <= payload[loc_idx];
      end
      if (|rem_gnt && remote_cnt != '1) remote_cnt <= remote_cnt + CNT_ONE;
      if (|loc_gnt && local_cnt != '1) local_cnt <= local_cnt + CNT_ONE;
      if (|ill_req) err_illegal_cell <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_dispatch_arbiter.sv
// Directed plus randomized bench for wb_dispatch_arbiter against a
// transaction-level reference model of classification, routing and arbitration.
module tb_wb_dispatch_arbiter;
  localparam int N    = 4;
  localparam int PAYW = 3*32 + 7;
  localparam int WBW  = 9 + PAYW;
  localparam int PKTW = PAYW + 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      wb_valid = '0;
  logic [N*WBW-1:0]  wb_data = '0;
  logic [N-1:0]      wb_ready;
  logic              pkt_valid;
  logic [PKTW-1:0]   pkt_data;
  logic              pkt_ready = 1'b0;
  logic              local_valid;
  logic [PAYW-1:0]   local_data;
  logic              local_ready = 1'b0;
  logic [15:0]       remote_cnt, local_cnt;
  logic              err_illegal_cell;

  always #5 clk = ~clk;

  wb_dispatch_arbiter dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_ready(wb_ready), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
    .pkt_ready(pkt_ready), .local_valid(local_valid), .local_data(local_data),
    .local_ready(local_ready), .remote_cnt(remote_cnt), .local_cnt(local_cnt),
    .err_illegal_cell(err_illegal_cell)
  );

  int passed = 0;
  int total  = 0;

  // reference model state
  bit              m_pv, m_lv, m_err;
  logic [PKTW-1:0] m_pd;
  logic [PAYW-1:0] m_ld;
  int              m_rp, m_lp, m_rc, m_lc;

  logic [WBW-1:0]  w [N];
  logic [N-1:0]    v;
  logic [N-1:0]    acc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // 0 = local, 1 = remote (offset lexicographically positive), 2 = illegal
  function automatic int mcls(input int z, input int y, input int x);
    int dz, dy, dx;
    dz = z - 2; dy = y - 2; dx = x - 2;
    if (z < 1 || z > 3 || y < 1 || y > 3 || x < 1 || x > 3) return 2;
    if (dz == 0 && dy == 0 && dx == 0) return 0;
    if (dz > 0 || (dz == 0 && dy > 0) || (dz == 0 && dy == 0 && dx > 0)) return 1;
    return 2;
  endfunction

  // home sits at 0-based (0,0,0), linear id 0
  function automatic int mdest(input int z, input int y, input int x);
    return ((x + 2) % 4) + 4 * ((y + 2) % 4) + 16 * ((z + 2) % 4);
  endfunction

  function automatic int fz(input logic [WBW-1:0] x); return int'(x[WBW-1 -: 3]); endfunction
  function automatic int fy(input logic [WBW-1:0] x); return int'(x[WBW-4 -: 3]); endfunction
  function automatic int fx(input logic [WBW-1:0] x); return int'(x[WBW-7 -: 3]); endfunction
  function automatic int wcls(input logic [WBW-1:0] x); return mcls(fz(x), fy(x), fx(x)); endfunction

  function automatic logic [WBW-1:0] mkw(input int z, input int y, input int x,
                                         input logic [PAYW-1:0] p);
    return {3'(z), 3'(y), 3'(x), p};
  endfunction

  function automatic logic [PAYW-1:0] rpay();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[PAYW-1:0];
  endfunction

  function automatic int rcoord();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 7));
    return int'($urandom_range(1, 3));
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) wb_data[i*WBW +: WBW] = w[i];
    wb_valid = v;
  endtask

  task automatic step(output logic [N-1:0] accepted);
    logic [N-1:0] er;
    int rg, lg, j;
    bit pload, lload;
    drive();
    #1;
    er = '0; rg = -1; lg = -1;
    pload = !m_pv || pkt_ready;
    lload = !m_lv || local_ready;
    for (int i = 0; i < N; i++) if (v[i] && wcls(w[i]) == 2) er[i] = 1'b1;
    for (int k = 0; k < N; k++) begin
      j = (m_rp + k) % N;
      if (pload && rg < 0 && v[j] && wcls(w[j]) == 1) rg = j;
      j = (m_lp + k) % N;
      if (lload && lg < 0 && v[j] && wcls(w[j]) == 0) lg = j;
    end
    if (rg >= 0) er[rg] = 1'b1;
    if (lg >= 0) er[lg] = 1'b1;
    chk("wb_ready", 128'(wb_ready), 128'(er));
    if (pload) begin
      m_pv = (rg >= 0);
      if (rg >= 0) begin
        m_pd = {6'(mdest(fz(w[rg]), fy(w[rg]), fx(w[rg]))), w[rg][PAYW-1:0]};
        m_rp = (rg + 1) % N;
        if (m_rc < 65535) m_rc++;
      end
    end
    if (lload) begin
      m_lv = (lg >= 0);
      if (lg >= 0) begin
        m_ld = w[lg][PAYW-1:0];
        m_lp = (lg + 1) % N;
        if (m_lc < 65535) m_lc++;
      end
    end
    for (int i = 0; i < N; i++) if (v[i] && wcls(w[i]) == 2) m_err = 1'b1;
    accepted = er;
    @(posedge clk); #1;
    chk("pkt_valid", 128'(pkt_valid), 128'(m_pv));
    chk("pkt_data", 128'(pkt_data), 128'(m_pd));
    chk("local_valid", 128'(local_valid), 128'(m_lv));
    chk("local_data", 128'(local_data), 128'(m_ld));
    chk("remote_cnt", 128'(remote_cnt), 128'(m_rc));
    chk("local_cnt", 128'(local_cnt), 128'(m_lc));
    chk("err_illegal", 128'(err_illegal_cell), 128'(m_err));
  endtask

  task automatic reset_cycle();
    logic [N-1:0] er;
    rst_n = 1'b0;
    drive();
    #1;
    er = '0;
    for (int i = 0; i < N; i++) if (v[i] && wcls(w[i]) == 2) er[i] = 1'b1;
    chk("rst_wb_ready", 128'(wb_ready), 128'(er));
    @(posedge clk); #1;
    m_pv = 0; m_lv = 0; m_err = 0; m_pd = '0; m_ld = '0;
    m_rp = 0; m_lp = 0; m_rc = 0; m_lc = 0;
    chk("rst_pkt_valid", 128'(pkt_valid), 128'(0));
    chk("rst_local_valid", 128'(local_valid), 128'(0));
    chk("rst_pkt_data", 128'(pkt_data), 128'(0));
    chk("rst_local_data", 128'(local_data), 128'(0));
    chk("rst_remote_cnt", 128'(remote_cnt), 128'(0));
    chk("rst_local_cnt", 128'(local_cnt), 128'(0));
    chk("rst_err", 128'(err_illegal_cell), 128'(0));
  endtask

  initial begin
    logic [PAYW-1:0] p0, p1, p2, p3, p4;
    logic [PKTW-1:0] held;
    v = '0;
    for (int i = 0; i < N; i++) w[i] = '0;
    reset_cycle();
    reset_cycle();
    rst_n = 1'b1;
    pkt_ready = 1'b1;
    local_ready = 1'b1;

    // single remote writeback, +z neighbour
    p0 = rpay();
    w[0] = mkw(3, 2, 2, p0); v = 4'b0001;
    step(acc);
    chk("t1_dest16", 128'(pkt_data[PKTW-1 -: 6]), 128'(16));
    chk("t1_payload", 128'(pkt_data[PAYW-1:0]), 128'(p0));
    chk("t1_rcnt", 128'(remote_cnt), 128'(1));
    v = '0; step(acc);

    // two remote requesters contend: pointer sits at 1
    p1 = rpay(); p2 = rpay();
    w[1] = mkw(2, 2, 3, p1); w[2] = mkw(2, 3, 1, p2); v = 4'b0110;
    step(acc);
    chk("t2_first_dest1", 128'(pkt_data[PKTW-1 -: 6]), 128'(1));
    chk("t2_first_payload", 128'(pkt_data[PAYW-1:0]), 128'(p1));
    v = 4'b0100;
    step(acc);
    chk("t2_second_dest7", 128'(pkt_data[PKTW-1 -: 6]), 128'(7));
    chk("t2_second_payload", 128'(pkt_data[PAYW-1:0]), 128'(p2));

    // local and remote granted in the same cycle
    p3 = rpay(); p4 = rpay();
    w[0] = mkw(2, 2, 2, p3); w[3] = mkw(3, 3, 3, p4); v = 4'b1001;
    step(acc);
    chk("t3_local_valid", 128'(local_valid), 128'(1));
    chk("t3_local_data", 128'(local_data), 128'(p3));
    chk("t3_pkt_valid", 128'(pkt_valid), 128'(1));
    chk("t3_dest21", 128'(pkt_data[PKTW-1 -: 6]), 128'(21));
    chk("t3_lcnt", 128'(local_cnt), 128'(1));

    // network backpressure with all requesters remote
    pkt_ready = 1'b0;
    for (int i = 0; i < N; i++) w[i] = mkw(3, i % 3 + 1, 2, rpay());
    v = 4'b1111;
    held = pkt_data;
    for (int c = 0; c < 5; c++) begin
      step(acc);
      chk("t4_pkt_stable", 128'(pkt_data), 128'(held));
      chk("t4_ready_low", 128'(wb_ready), 128'(0));
    end
    pkt_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      step(acc);
      chk("t4_order", 128'(pkt_data[PAYW-1:0]), 128'(w[k][PAYW-1:0]));
      v[k] = 1'b0;
    end
    v = '0; step(acc);

    // illegal cell is swallowed and sticks the error flag
    w[2] = mkw(1, 1, 1, rpay()); v = 4'b0100;
    step(acc);
    chk("t5_no_pkt", 128'(pkt_valid), 128'(0));
    chk("t5_no_local", 128'(local_valid), 128'(0));
    chk("t5_err_set", 128'(err_illegal_cell), 128'(1));
    v = '0;
    for (int c = 0; c < 3; c++) begin
      step(acc);
      chk("t5_err_sticky", 128'(err_illegal_cell), 128'(1));
    end

    // randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      pkt_ready   = ($urandom_range(0, 3) != 0);
      local_ready = ($urandom_range(0, 3) != 0);
      step(acc);
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !v[i]) begin
          v[i] = ($urandom_range(0, 2) != 0);
          w[i] = mkw(rcoord(), rcoord(), rcoord(), rpay());
        end
      end
    end

    // reset while a packet is stalled
    pkt_ready = 1'b0;
    for (int i = 0; i < N; i++) w[i] = mkw(3, 2, i % 3 + 1, rpay());
    v = 4'b1111;
    step(acc);
    step(acc);
    chk("t6_stalled", 128'(pkt_valid), 128'(1));
    reset_cycle();
    rst_n = 1'b1;
    pkt_ready = 1'b1;
    step(acc);
    chk("t6_ptr_reset", 128'(pkt_data[PAYW-1:0]), 128'(w[0][PAYW-1:0]));
    chk("t6_rcnt", 128'(remote_cnt), 128'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wb_dispatch_arbiter.md
Name: wb_dispatch_arbiter

Overview:
- Shares the cell-to-destination mapping path and the ring-network injection port among NUM_REQ force-pipeline writeback sources inside one MD cell node.
- Classifies each writeback by its cell triple:
  - home cell {2,2,2} goes to the local force-cache port;
  - half-shell neighbour goes to the network port as a routed packet;
  - any other triple is dropped and flagged as illegal.
- Runs two independent round-robin arbiters, one for local and one for remote, so up to two grants can issue per cycle.
- Each output has a registered valid/ready stage.

Parameters:
- NUM_REQ, 4, number of writeback requesters.
- NUM_CELLS, 64, total cells in the system.
- DATA_WIDTH, 32, width of one force component.
- CELL_ID_WIDTH, 3, width of one cell coordinate.
- PARTICLE_ID_WIDTH, 7, particle index width.
- WB_WIDTH, 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH+3*DATA_WIDTH, writeback word width.
- NODE_ID_WIDTH, 6, destination node id width.
- PAYLOAD_WIDTH, 3*DATA_WIDTH+PARTICLE_ID_WIDTH, force plus particle id width.
- PACKET_WIDTH, PAYLOAD_WIDTH+NODE_ID_WIDTH, network packet width.
- HOME_CELL_ID, 0, linear id of this node.
- HOME_X / HOME_Y / HOME_Z, 1 / 1 / 1, 1-based home coordinates.
- NX / NY / NZ, 4 / 4 / 4, grid dimensions.
- CNT_WIDTH, 16, width of the transfer counters.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, synchronous active-low reset.
- wb_valid, in, NUM_REQ, per-requester valid.
- wb_data, in, NUM_REQ*WB_WIDTH, packed writebacks; requester i occupies [i*WB_WIDTH +: WB_WIDTH].
- wb_ready, out, NUM_REQ, per-requester accept.
- pkt_valid, out, 1, network packet valid.
- pkt_data, out, PACKET_WIDTH, {dest_id, payload}.
- pkt_ready, in, 1, network accepts the packet.
- local_valid, out, 1, local force valid.
- local_data, out, PAYLOAD_WIDTH, wb payload (low PAYLOAD_WIDTH bits).
- local_ready, in, 1, force cache accepts the data.
- remote_cnt, out, CNT_WIDTH, accepted remote writebacks.
- local_cnt, out, CNT_WIDTH, accepted local writebacks.
- err_illegal_cell, out, 1, sticky illegal-cell flag.

Behaviour:
- Writeback word layout, MSB first: cellz, celly, cellx, then payload. Payload is force components above the particle id, which sits at the LSBs.
- Classification is combinational per requester:
  - local if {z,y,x} == {2,2,2};
  - remote if the triple is one of the 13 half-shell codes: {2,2,3}, {2,3,1..3}, {3,1..3,1..3};
  - illegal otherwise.
- Illegal: wb_ready=1 whenever wb_valid=1. The word is dropped and err_illegal_cell is set. The flag clears only on reset.
- Output stage: each output is a single register, load_en = !valid || ready.
- Remote arbiter:
  - candidates are valid remote requesters;
  - when the remote load_en is high, grant the first candidate at or after rr_remote;
  - wb_ready[g]=1 for the winner only;
  - register pkt_data = {dest_id(g), payload(g)} and set pkt_valid=1;
  - rr_remote <= (g+1) mod NUM_REQ;
  - with no grant, the pointer holds.
- Local arbiter: identical structure with rr_local, local_data, local_valid.
- A requester belongs to exactly one class, so it never receives two grants.
- wb_ready is combinational from wb_valid, classification, pointers and load_en.
- Output valid clears when ready=1 and no new grant lands that cycle.
- Latency: one cycle from input handshake to output valid. Throughput is one per output per cycle under continuous ready.
- dest_id is computed from hops:
  - hops uses the periodic-boundary rules per triple;
  - dest = HOME_CELL_ID+hops, minus NUM_CELLS if the sum is >= NUM_CELLS;
  - the sum is computed at 32 bits, then truncated to NODE_ID_WIDTH.
- Counters increment on each accepted local/remote input handshake and saturate at all-ones.
- Reset state:
  - pkt_valid=0, local_valid=0;
  - pkt_data=0, local_data=0;
  - rr pointers=0, counters=0, err_illegal_cell=0;
  - wb_ready follows its combinational rule; no grants until rst_n is high.
- Reset mid-transfer discards held outputs without completing a handshake.
- Backpressure: while an output is valid and its ready is low, that class sees no grants; the other class proceeds unaffected.

Decomposition:
- Package md_wb_pkg holds:
  - CELL_1/CELL_2/CELL_3 constants;
  - the home triple constant;
  - the wb_class_t enum {WB_LOCAL, WB_REMOTE, WB_ILLEGAL};
  - a function is_half_shell(z,y,x).
- One natural sub-module: rr_arbiter, parameterised NUM_REQ, with req/advance/grant_onehot/pointer. Instantiate it twice.
- Instantiate the existing cell-to-destination mapper once per requester. Its input is the classified word, and it supplies dest_id, so mapping is never done in this block.

Test Plan:
- Req0 sends {z,y,x}={3,2,2}, pkt_ready=1 -> the next cycle pkt_valid=1, pkt_data[PACKET_WIDTH-1-:6]=16, payload matches, remote_cnt=1.
- Req1 sends {2,2,3} and req2 sends {2,3,1} in the same cycle, pkt_ready=1 -> req1 is granted first (dest 1), then req2 (dest 7); rr_remote ends at 3.
- Req0 sends {2,2,2} and req3 sends {3,3,3} together -> both are granted in one cycle: local_valid=1 with the payload, pkt_valid=1 with dest 21.
- pkt_ready=0 for 5 cycles with all 4 requesters remote -> pkt_data is stable, wb_ready=0 throughout. After release, grants go 0,1,2,3 on consecutive cycles.
- Req2 sends {1,1,1} -> wb_ready[2]=1 in the same cycle, no output, err_illegal_cell=1, and it stays 1 until rst_n=0.
- rst_n=0 while pkt_valid=1 and pkt_ready=0 -> the next edge gives pkt_valid=0, counters=0, pointers=0.
